ram_line_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the single-port, cache-line-wide main BRAM.
- Port 0 is the instruction-cache refill path (read-only). Port 1 is the data-cache refill and writeback path (read or strobed write).
- Issues one RAM operation at a time, absorbs the RAM's registered 1-cycle read latency, and returns line-wide responses with valid/ready handshakes.
- Blocks new grants while UART programming mode is active.

---
 rtl/ram_line_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_ram_line_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_line_arbiter.sv
// ram_line_arbiter
// Two-requester arbiter/sequencer in front of the single-port, line-wide main
// BRAM. Port I is the instruction-cache refill path (read only). Port D is the
// data-cache refill/writeback path (read or byte-strobed write). One RAM
// operation is in flight at a time. The RAM's registered 1-cycle read latency
// is absorbed here, and a line-wide response is returned with a valid/ready
// handshake. While prog_mode_i is high, no new grant is issued.
//
// Build option: define RAM_ARB_PERF_EN to add saturating performance counters
// (perf_i_grants_o, perf_d_grants_o, perf_conflict_o). Without the macro those
// ports and their logic are absent.
module ram_line_arbiter #(
    parameter int CACHE_LINE_WIDTH = 128,
    parameter int RAM_DEPTH        = 32768,
    parameter int ADDR_W           = $clog2(RAM_DEPTH)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          prog_mode_i,
    // I port (read only)
    input  logic                          i_req_valid_i,
    output logic                          i_req_ready_o,
    input  logic [ADDR_W-1:0]             i_req_addr_i,
    output logic                          i_rsp_valid_o,
    input  logic                          i_rsp_ready_i,
    output logic [CACHE_LINE_WIDTH-1:0]   i_rsp_data_o,
    // D port (read or strobed write)
    input  logic                          d_req_valid_i,
    output logic                          d_req_ready_o,
    input  logic                          d_req_we_i,
    input  logic [ADDR_W-1:0]             d_req_addr_i,
    input  logic [CACHE_LINE_WIDTH-1:0]   d_req_wdata_i,
    input  logic [CACHE_LINE_WIDTH/8-1:0] d_req_wstrb_i,
    output logic                          d_rsp_valid_o,
    input  logic                          d_rsp_ready_i,
    output logic [CACHE_LINE_WIDTH-1:0]   d_rsp_data_o,
    // RAM side
    output logic [ADDR_W-1:0]             ram_addr_o,
    output logic [CACHE_LINE_WIDTH-1:0]   ram_wdata_o,
    output logic [CACHE_LINE_WIDTH/8-1:0] ram_wstrb_o,
    output logic                          ram_rd_en_o,
    input  logic [CACHE_LINE_WIDTH-1:0]   ram_rdata_i
`ifdef RAM_ARB_PERF_EN
    ,
    output logic [31:0]                   perf_i_grants_o,
    output logic [31:0]                   perf_d_grants_o,
    output logic [31:0]                   perf_conflict_o
`endif
);

    localparam int STRB_W = CACHE_LINE_WIDTH / 8;

    // Port identifiers used for the round-robin pointer and the owner register.
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    // Port granted most recently. It selects the response owner while busy and
    // acts as the round-robin pointer in IDLE. Reset to D so the first tie goes
    // to I.
    logic                        grant_q, grant_d;
    logic [CACHE_LINE_WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic grant_en;
    logic winner;
    logic grant_i;
    logic grant_d_port;
    logic grant_rd;
    logic grant_wr;
    logic rsp_active;
    logic rsp_ready_sel;

    // Winner selection: a lone requester wins, and a tie goes to the port that
    // was not granted last. The rst_ni term keeps every output at zero while
    // reset is held, even if requests are present.
    always_comb begin
        grant_en = 1'b0;
        winner   = PORT_I;
        if (rst_ni && (state_q == IDLE) && !prog_mode_i &&
            (i_req_valid_i || d_req_valid_i)) begin
            grant_en = 1'b1;
        end
        if (i_req_valid_i && d_req_valid_i) begin
            winner = ~grant_q;
        end else if (d_req_valid_i) begin
            winner = PORT_D;
        end else begin
            winner = PORT_I;
        end
    end

    assign grant_i      = grant_en && (winner == PORT_I);
    assign grant_d_port = grant_en && (winner == PORT_D);
    assign grant_wr     = grant_d_port && d_req_we_i;
    assign grant_rd     = grant_i || (grant_d_port && !d_req_we_i);

    // Request-side and RAM-side outputs are valid only in the grant cycle.
    always_comb begin
        i_req_ready_o = grant_i;
        d_req_ready_o = grant_d_port;
        ram_rd_en_o   = grant_rd;
        ram_addr_o    = '0;
        ram_wdata_o   = '0;
        ram_wstrb_o   = '0;
        if (grant_i) begin
            ram_addr_o = i_req_addr_i;
        end else if (grant_d_port) begin
            ram_addr_o = d_req_addr_i;
        end
        if (grant_wr) begin
            ram_wdata_o = d_req_wdata_i;
            ram_wstrb_o = d_req_wstrb_i;
        end
    end

    // Response side: only the owning port ever sees valid or data.
    always_comb begin
        rsp_active    = (state_q == RESP);
        i_rsp_valid_o = rsp_active && (grant_q == PORT_I);
        d_rsp_valid_o = rsp_active && (grant_q == PORT_D);
        i_rsp_data_o  = i_rsp_valid_o ? rsp_data_q : '0;
        d_rsp_data_o  = d_rsp_valid_o ? rsp_data_q : '0;
        rsp_ready_sel = (grant_q == PORT_I) ? i_rsp_ready_i : d_rsp_ready_i;
    end

    // Next-state logic. Leaving RESP always goes through IDLE, so there is
    // never a grant in the handshake cycle.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rsp_data_d = rsp_data_q;
        unique case (state_q)
            IDLE: begin
                if (grant_en) begin
                    grant_d = winner;
                    if (grant_wr) begin
                        rsp_data_d = '0;
                        state_d    = RESP;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                // RAM data registered from the grant-cycle read is valid now.
                rsp_data_d = ram_rdata_i;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready_sel) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, owner and response-holding registers. An asynchronous reset drops
    // any pending response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            grant_q    <= PORT_D;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rsp_data_q <= rsp_data_d;
        end
    end

`ifdef RAM_ARB_PERF_EN
    logic [31:0] perf_i_q, perf_d_q, perf_conf_q;
    logic [31:0] perf_i_d, perf_d_d, perf_conf_d;
    logic        lost_cycle;

    // A cycle is lost when both ports want the RAM but no grant is possible.
    assign lost_cycle = i_req_valid_i && d_req_valid_i &&
                        !((state_q == IDLE) && !prog_mode_i);

    // Saturating increments: the counters stick at all-ones instead of
    // wrapping.
    always_comb begin
        perf_i_d    = perf_i_q;
        perf_d_d    = perf_d_q;
        perf_conf_d = perf_conf_q;
        if (grant_i && (perf_i_q != 32'hFFFF_FFFF)) begin
            perf_i_d = perf_i_q + 32'd1;
        end
        if (grant_d_port && (perf_d_q != 32'hFFFF_FFFF)) begin
            perf_d_d = perf_d_q + 32'd1;
        end
        if (lost_cycle && (perf_conf_q != 32'hFFFF_FFFF)) begin
            perf_conf_d = perf_conf_q + 32'd1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_i_q    <= '0;
            perf_d_q    <= '0;
            perf_conf_q <= '0;
        end else begin
            perf_i_q    <= perf_i_d;
            perf_d_q    <= perf_d_d;
            perf_conf_q <= perf_conf_d;
        end
    end

    assign perf_i_grants_o = perf_i_q;
    assign perf_d_grants_o = perf_d_q;
    assign perf_conflict_o = perf_conf_q;
`endif

    // Byte strobes cover the whole line. This width is used only by the ports.
    logic [STRB_W-1:0] unused_strb_w;
    assign unused_strb_w = '0;

endmodule

// File: tb/tb_ram_line_arbiter.sv
// Directed testbench for ram_line_arbiter. A small registered RAM model
// returns a per-address line one cycle after ram_rd_en_o and returns junk
// otherwise. Inputs are driven at posedge+1 and outputs are sampled at
// posedge+4.
`timescale 1ns/1ps
module tb_ram_line_arbiter;

    localparam int LW = 128;
    localparam int SW = LW / 8;
    localparam int AW = 15;

    logic          clk;
    logic          rst_n;
    logic          prog_mode;
    logic          i_req_valid, i_req_ready, i_rsp_valid, i_rsp_ready;
    logic [AW-1:0] i_req_addr;
    logic [LW-1:0] i_rsp_data;
    logic          d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_ready;
    logic [AW-1:0] d_req_addr;
    logic [LW-1:0] d_req_wdata, d_rsp_data;
    logic [SW-1:0] d_req_wstrb;
    logic [AW-1:0] ram_addr;
    logic [LW-1:0] ram_wdata, ram_rdata;
    logic [SW-1:0] ram_wstrb;
    logic          ram_rd_en;
`ifdef RAM_ARB_PERF_EN
    logic [31:0]   perf_i, perf_d, perf_c;
`endif

    int checks   = 0;
    int failures = 0;

    ram_line_arbiter #(.CACHE_LINE_WIDTH(LW), .RAM_DEPTH(32768)) dut (
        .clk_i(clk), .rst_ni(rst_n), .prog_mode_i(prog_mode),
        .i_req_valid_i(i_req_valid), .i_req_ready_o(i_req_ready),
        .i_req_addr_i(i_req_addr), .i_rsp_valid_o(i_rsp_valid),
        .i_rsp_ready_i(i_rsp_ready), .i_rsp_data_o(i_rsp_data),
        .d_req_valid_i(d_req_valid), .d_req_ready_o(d_req_ready),
        .d_req_we_i(d_req_we), .d_req_addr_i(d_req_addr),
        .d_req_wdata_i(d_req_wdata), .d_req_wstrb_i(d_req_wstrb),
        .d_rsp_valid_o(d_rsp_valid), .d_rsp_ready_i(d_rsp_ready),
        .d_rsp_data_o(d_rsp_data),
        .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_wstrb_o(ram_wstrb),
        .ram_rd_en_o(ram_rd_en), .ram_rdata_i(ram_rdata)
`ifdef RAM_ARB_PERF_EN
        , .perf_i_grants_o(perf_i), .perf_d_grants_o(perf_d), .perf_conflict_o(perf_c)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected contents of one RAM line.
    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        logic [31:0] w;
        if (a == 15'h10) return 128'h0123456789ABCDEF_0123456789ABCDEF;
        w = 32'hC0DE_0000 ^ {17'd0, a};
        return {w, w, w, w};
    endfunction

    // Registered RAM: valid data one cycle after a read, junk otherwise.
    always @(posedge clk) begin
        if (ram_rd_en) ram_rdata <= line_of(ram_addr);
        else           ram_rdata <= {4{32'hDEAD_BEEF}};
    end

    // Any output activity at all (used for the all-zero checks).
    logic [9:0] any_out;
    assign any_out = {i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid, ram_rd_en,
                      |ram_wstrb, |ram_addr, |ram_wdata, |i_rsp_data, |d_rsp_data};
    // RAM or request activity that must be absent while busy or frozen.
    logic [3:0] ram_act;
    assign ram_act = {ram_rd_en, |ram_wstrb, i_req_ready, d_req_ready};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        prog_mode = 0; i_req_valid = 0; i_req_addr = '0; i_rsp_ready = 0;
        d_req_valid = 0; d_req_we = 0; d_req_addr = '0; d_req_wdata = '0;
        d_req_wstrb = '0; d_rsp_ready = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        cyc(); cyc();
        rst_n = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        #2;
        checks++; if (any_out !== 10'd0) begin failures++; $display("FAIL reset_outs_in_reset: got %b want 0", any_out); end
        cyc(); cyc();
        rst_n = 1;
        #3;
        checks++; if (any_out !== 10'd0) begin failures++; $display("FAIL reset_outs_after_release: got %b want 0", any_out); end
        $display("txn reset done");
    endtask

    task automatic test_single_read();
        cyc();
        i_req_valid = 1; i_req_addr = 15'h10; i_rsp_ready = 1;
        #3;
        checks++; if ({i_req_ready, d_req_ready, ram_rd_en} !== 3'b101) begin failures++; $display("FAIL rd_grant: got %b want 101", {i_req_ready, d_req_ready, ram_rd_en}); end
        checks++; if (ram_addr !== 15'h10 || ram_wstrb !== '0) begin failures++; $display("FAIL rd_addr: got addr=%h wstrb=%h want 10/0", ram_addr, ram_wstrb); end
        cyc();
        i_req_valid = 0;
        #3;
        checks++; if ({ram_rd_en, i_rsp_valid, d_rsp_valid} !== 3'b000) begin failures++; $display("FAIL rd_cycle1: got %b want 000", {ram_rd_en, i_rsp_valid, d_rsp_valid}); end
        cyc(); #3;
        checks++; if ({i_rsp_valid, d_rsp_valid} !== 2'b10) begin failures++; $display("FAIL rd_cycle2_valid: got %b want 10", {i_rsp_valid, d_rsp_valid}); end
        checks++; if (i_rsp_data !== 128'h0123456789ABCDEF_0123456789ABCDEF) begin failures++; $display("FAIL rd_data: got %h want 0123456789abcdef0123456789abcdef", i_rsp_data); end
        cyc(); #3;
        checks++; if (i_rsp_valid !== 1'b0) begin failures++; $display("FAIL rd_cycle3_valid: got %b want 0", i_rsp_valid); end
        i_rsp_ready = 0;
        $display("txn I read addr=010");
    endtask

    task automatic test_single_write();
        cyc();
        d_req_valid = 1; d_req_we = 1; d_req_addr = 15'h20; d_req_wstrb = 16'h00F0;
        d_req_wdata = {16{8'hAA}}; d_rsp_ready = 1;
        #3;
        checks++; if ({d_req_ready, i_req_ready, ram_rd_en} !== 3'b100) begin failures++; $display("FAIL wr_grant: got %b want 100", {d_req_ready, i_req_ready, ram_rd_en}); end
        checks++; if (ram_wstrb !== 16'h00F0 || ram_wdata !== {16{8'hAA}} || ram_addr !== 15'h20) begin failures++; $display("FAIL wr_ram: got wstrb=%h addr=%h wdata=%h want 00f0/20/aa..", ram_wstrb, ram_addr, ram_wdata); end
        cyc();
        d_req_valid = 0; d_req_we = 0;
        #3;
        checks++; if (ram_wstrb !== '0) begin failures++; $display("FAIL wr_strb_pulse: got %h want 0", ram_wstrb); end
        checks++; if ({d_rsp_valid, i_rsp_valid} !== 2'b10 || d_rsp_data !== '0) begin failures++; $display("FAIL wr_rsp: got v=%b data=%h want 10/0", {d_rsp_valid, i_rsp_valid}, d_rsp_data); end
        cyc(); #3;
        checks++; if (d_rsp_valid !== 1'b0) begin failures++; $display("FAIL wr_rsp_done: got %b want 0", d_rsp_valid); end
        d_rsp_ready = 0;
        $display("txn D write addr=020");
    endtask

    task automatic test_round_robin();
        logic          exp_d;
        logic [AW-1:0] exp_addr;
        logic [LW-1:0] got;
        do_reset();
        i_req_valid = 1; i_req_addr = 15'h40;
        d_req_valid = 1; d_req_we = 0; d_req_addr = 15'h80;
        #3;
        for (int t = 0; t < 4; t++) begin
            exp_d    = (t % 2) == 1;
            exp_addr = exp_d ? 15'h80 : 15'h40;
            if (t != 0) begin
                cyc();
                i_rsp_ready = 0; d_rsp_ready = 0;
                #3;
            end
            checks++; if ({i_req_ready, d_req_ready} !== (exp_d ? 2'b01 : 2'b10)) begin failures++; $display("FAIL rr_grant%0d: got %b want %b", t, {i_req_ready, d_req_ready}, exp_d ? 2'b01 : 2'b10); end
            checks++; if (ram_rd_en !== 1'b1 || ram_addr !== exp_addr) begin failures++; $display("FAIL rr_ram%0d: got en=%b addr=%h want 1/%h", t, ram_rd_en, ram_addr, exp_addr); end
            cyc(); #3;
            checks++; if ({ram_act, i_rsp_valid, d_rsp_valid} !== 6'd0) begin failures++; $display("FAIL rr_wait%0d: got %b want 0", t, {ram_act, i_rsp_valid, d_rsp_valid}); end
            for (int s = 0; s < 4; s++) begin
                cyc();
                if (s == 3) begin
                    if (exp_d) d_rsp_ready = 1; else i_rsp_ready = 1;
                end
                #3;
                got = exp_d ? d_rsp_data : i_rsp_data;
                checks++; if ({i_rsp_valid, d_rsp_valid} !== (exp_d ? 2'b01 : 2'b10) || got !== line_of(exp_addr)) begin failures++; $display("FAIL rr_rsp%0d_s%0d: got v=%b data=%h want %b/%h", t, s, {i_rsp_valid, d_rsp_valid}, got, exp_d ? 2'b01 : 2'b10, line_of(exp_addr)); end
                checks++; if (ram_act !== 4'd0) begin failures++; $display("FAIL rr_quiet%0d_s%0d: got %b want 0", t, s, ram_act); end
            end
            $display("txn RR %s read addr=%h", exp_d ? "D" : "I", exp_addr);
        end
        cyc();
        clear_inputs();
    endtask

    task automatic test_prog_mode();
        cyc();
        i_req_valid = 1; i_req_addr = 15'h100; i_rsp_ready = 1;
        #3;
        checks++; if ({i_req_ready, ram_rd_en} !== 2'b11) begin failures++; $display("FAIL pm_grant: got %b want 11", {i_req_ready, ram_rd_en}); end
        cyc();
        prog_mode = 1; i_req_addr = 15'h140;
        d_req_valid = 1; d_req_we = 0; d_req_addr = 15'h200;
        #3;
        checks++; if (ram_act !== 4'd0) begin failures++; $display("FAIL pm_wait_quiet: got %b want 0", ram_act); end
        cyc(); #3;
        checks++; if (i_rsp_valid !== 1'b1 || i_rsp_data !== line_of(15'h100)) begin failures++; $display("FAIL pm_inflight_rsp: got v=%b data=%h want 1/%h", i_rsp_valid, i_rsp_data, line_of(15'h100)); end
        for (int k = 3; k <= 10; k++) begin
            cyc(); #3;
            checks++; if ({ram_act, i_rsp_valid, d_rsp_valid} !== 6'd0) begin failures++; $display("FAIL pm_frozen_c%0d: got %b want 0", k, {ram_act, i_rsp_valid, d_rsp_valid}); end
        end
        cyc();
        prog_mode = 0;
        #3;
        checks++; if ({i_req_ready, d_req_ready, ram_rd_en} !== 3'b011 || ram_addr !== 15'h200) begin failures++; $display("FAIL pm_first_grant: got %b addr=%h want 011/200", {i_req_ready, d_req_ready, ram_rd_en}, ram_addr); end
        cyc();
        i_req_valid = 0; d_req_valid = 0; i_rsp_ready = 0; d_rsp_ready = 1;
        cyc(); #3;
        checks++; if ({i_rsp_valid, d_rsp_valid} !== 2'b01 || d_rsp_data !== line_of(15'h200)) begin failures++; $display("FAIL pm_d_rsp: got v=%b data=%h want 01/%h", {i_rsp_valid, d_rsp_valid}, d_rsp_data, line_of(15'h200)); end
        cyc();
        clear_inputs();
        $display("txn prog-mode I read addr=100 then D read addr=200");
    endtask

    task automatic test_async_reset();
        cyc();
        i_req_valid = 1; i_req_addr = 15'h33; i_rsp_ready = 0;
        cyc();
        i_req_valid = 0;
        cyc(); #3;
        checks++; if (i_rsp_valid !== 1'b1) begin failures++; $display("FAIL ar_pre_valid: got %b want 1", i_rsp_valid); end
        i_req_valid = 1; d_req_valid = 1; d_req_addr = 15'h44;
        rst_n = 0;
        #1;
        checks++; if (any_out !== 10'd0) begin failures++; $display("FAIL ar_outs_zero: got %b want 0", any_out); end
        cyc();
        rst_n = 1;
        #3;
        checks++; if ({i_req_ready, d_req_ready} !== 2'b10 || ram_addr !== 15'h33) begin failures++; $display("FAIL ar_first_grant: got %b addr=%h want 10/33", {i_req_ready, d_req_ready}, ram_addr); end
        cyc();
        i_req_valid = 0; d_req_valid = 0; i_rsp_ready = 1;
        cyc(); cyc();
        clear_inputs();
        $display("txn async reset in RESP, then I read addr=033");
    endtask

    task automatic test_back_to_back();
        cyc();
        d_req_valid = 1; d_req_we = 1; d_req_addr = 15'h300; d_req_wstrb = 16'hFFFF;
        d_req_wdata = {8{16'h5A3C}}; d_rsp_ready = 1;
        for (int c = 0; c < 5; c++) begin
            #3;
            checks++; if ({d_req_ready, |ram_wstrb, d_rsp_valid} !== ((c % 2 == 0) ? 3'b110 : 3'b001)) begin failures++; $display("FAIL b2b_c%0d: got %b want %b", c, {d_req_ready, |ram_wstrb, d_rsp_valid}, (c % 2 == 0) ? 3'b110 : 3'b001); end
            if (c < 4) cyc();
        end
        cyc();
        d_req_valid = 0;
        cyc();
        clear_inputs();
        $display("txn back-to-back D writes addr=300 x3");
    endtask

`ifdef RAM_ARB_PERF_EN
    task automatic test_perf();
        int exp_conf;
        exp_conf = 0;
        do_reset();
        for (int c = 0; c <= 21; c++) begin
            if (c != 0) cyc();
            i_req_valid = (c <= 18); i_req_addr = 15'h500;
            d_req_valid = (c <= 15); d_req_we = 0; d_req_addr = 15'h600;
            i_rsp_ready = 1; d_rsp_ready = 1;
            if (i_req_valid && d_req_valid && (c % 3) != 0) exp_conf++;
            #3;
        end
        cyc(); #3;
        checks++; if (perf_i !== 32'd4) begin failures++; $display("FAIL perf_i: got %0d want 4", perf_i); end
        checks++; if (perf_d !== 32'd3) begin failures++; $display("FAIL perf_d: got %0d want 3", perf_d); end
        checks++; if (perf_c !== exp_conf) begin failures++; $display("FAIL perf_conflict: got %0d want %0d", perf_c, exp_conf); end
        clear_inputs();
        $display("txn perf run 4 I + 3 D");
    endtask
`endif

    initial begin
        rst_n = 0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_single_write();
        test_round_robin();
        test_prog_mode();
        test_async_reset();
        test_back_to_back();
`ifdef RAM_ARB_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
